// File: rtl/mult_pkg.sv
// Definitions shared by the multiply/divide unit: operand width, step counter
// width, control state encoding and Booth recode values.
package mult_pkg;

   localparam int MD_WIDTH   = 32;
   localparam int STEP_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } md_state_e;

   // {Q[0], q_1} pairs that move the partial product
   localparam logic [1:0] ADD = 2'b01;
   localparam logic [1:0] SUB = 2'b10;

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of the combined {A, Q, q_1} register.
module mult_booth_step
   import mult_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic [2*WIDTH+1:0] aqq,
   input  logic [WIDTH-1:0]   m,
   output logic [2*WIDTH+1:0] aqq_next
);

   logic [WIDTH:0] a_s;
   logic [WIDTH:0] m_sx_s;
   logic [WIDTH:0] sum_s;

   assign a_s    = aqq[2*WIDTH+1:WIDTH+1];
   assign m_sx_s = {m[WIDTH-1], m};

   // Add or subtract M according to the recoded pair {Q[0], q_1}
   always_comb begin
      sum_s = a_s;
      case (aqq[1:0])
         ADD:     sum_s = a_s + m_sx_s;
         SUB:     sum_s = a_s - m_sx_s;
         default: sum_s = a_s;
      endcase
   end

   assign aqq_next = {sum_s[WIDTH], sum_s, aqq[WIDTH:1]};

endmodule

// File: rtl/mult.sv
// Sequential signed Booth multiplier with a start/ready handshake; returns the
// low half of the product and a flag when the product does not fit.
module mult
   import mult_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   input  logic             CTRL,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             ready
);

   localparam int AQQ_W = 2 * WIDTH + 2;
   localparam logic [STEP_CNT_W-1:0] LAST_CNT = STEP_CNT_W'(WIDTH - 1);
   localparam logic [STEP_CNT_W-1:0] CNT_ONE  = STEP_CNT_W'(1);

   md_state_e             state_r, state_n;
   logic [STEP_CNT_W-1:0] cnt_r, cnt_n;
   logic [WIDTH-1:0]      m_r, m_n;
   logic [AQQ_W-1:0]      aqq_r, aqq_n;
   logic [WIDTH-1:0]      result_r, result_n;
   logic                  ovf_r, ovf_n;
   logic                  ready_r, ready_n;

   logic [AQQ_W-1:0]      step_s;
   logic [2*WIDTH-1:0]    prod_s;
   logic                  prod_ovf_s;

   mult_booth_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .aqq      (aqq_r),
      .m        (m_r),
      .aqq_next (step_s)
   );

   // The product after the final step skips the A guard bit and q_1
   assign prod_s     = step_s[2*WIDTH:1];
   assign prod_ovf_s = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});

   // Next-state, datapath and output update; CTRL always wins and restarts
   always_comb begin
      state_n  = state_r;
      cnt_n    = cnt_r;
      m_n      = m_r;
      aqq_n    = aqq_r;
      result_n = result_r;
      ovf_n    = ovf_r;
      ready_n  = 1'b0;
      if (CTRL) begin
         m_n     = multiplicand;
         aqq_n   = {{(WIDTH + 1){1'b0}}, multiplier, 1'b0};
         cnt_n   = {STEP_CNT_W{1'b0}};
         state_n = BUSY;
      end else begin
         case (state_r)
            IDLE: state_n = IDLE;
            BUSY: begin
               aqq_n = step_s;
               cnt_n = cnt_r + CNT_ONE;
               if (cnt_r == LAST_CNT) begin
                  result_n = prod_s[WIDTH-1:0];
                  ovf_n    = prod_ovf_s;
                  ready_n  = 1'b1;
                  state_n  = DONE;
               end else begin
                  state_n  = BUSY;
               end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r  <= IDLE;
         cnt_r    <= {STEP_CNT_W{1'b0}};
         m_r      <= {WIDTH{1'b0}};
         aqq_r    <= {AQQ_W{1'b0}};
         result_r <= {WIDTH{1'b0}};
         ovf_r    <= 1'b0;
         ready_r  <= 1'b0;
      end else begin
         state_r  <= state_n;
         cnt_r    <= cnt_n;
         m_r      <= m_n;
         aqq_r    <= aqq_n;
         result_r <= result_n;
         ovf_r    <= ovf_n;
         ready_r  <= ready_n;
      end
   end

   assign result   = result_r;
   assign overflow = ovf_r;
   assign ready    = ready_r;

endmodule
